// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Pipeline hazard controller: detects load-use hazards, squashes the
//   instruction behind a taken branch, and picks the operand source for each
//   ID source field.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   RUN   | normal issue; a load-use hazard or a taken branch is acted on
//   STALL | one-cycle bubble after a load-use hazard; EX now holds a NOP
//   FLUSH | ID holds the squashed instruction behind a taken branch
//
// Ports
//   Clk, Clr                      clock, async active-high reset
//   ID_Rn/Rm/Rd, ID_use_*         source fields of the instruction in ID
//   EX_RD, EX_RF_enable, EX_load_instr
//   MEM_RD, MEM_RF_enable, WB_RD, WB_RF_enable
//   Branch_taken                  B/BL in ID resolved taken
//   PC_LE, IF_ID_LE, IF_ID_flush, CU_MUX_E   pipeline control
//   FWD_A/B/D                     00 RF, 01 EX, 10 MEM, 11 WB
//   stall_cnt, flush_cnt          saturating event counters
module hazard_control_unit #(
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [3:0]       ID_Rn,
  input  logic [3:0]       ID_Rm,
  input  logic [3:0]       ID_Rd,
  input  logic             ID_use_Rn,
  input  logic             ID_use_Rm,
  input  logic             ID_use_Rd,
  input  logic [3:0]       EX_RD,
  input  logic             EX_RF_enable,
  input  logic             EX_load_instr,
  input  logic [3:0]       MEM_RD,
  input  logic             MEM_RF_enable,
  input  logic [3:0]       WB_RD,
  input  logic             WB_RF_enable,
  input  logic             Branch_taken,
  output logic             PC_LE,
  output logic             IF_ID_LE,
  output logic             IF_ID_flush,
  output logic             CU_MUX_E,
  output logic [1:0]       FWD_A,
  output logic [1:0]       FWD_B,
  output logic [1:0]       FWD_D,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, next_state;
  logic   lu;

  function automatic logic [1:0] fwd_sel(
    input logic [3:0] src,
    input logic       use_src,
    input logic [3:0] ex_rd,
    input logic       ex_fwd_ok,
    input logic [3:0] mem_rd,
    input logic       mem_en,
    input logic [3:0] wb_rd,
    input logic       wb_en
  );
    logic [1:0] sel;
    sel = 2'b00;
    // R15 reads the PC, never a forwarded result
    if (use_src && src != 4'd15) begin
      if (ex_fwd_ok && src == ex_rd)   sel = 2'b01;
      else if (mem_en && src == mem_rd) sel = 2'b10;
      else if (wb_en && src == wb_rd)   sel = 2'b11;
    end
    return sel;
  endfunction

  assign lu = EX_load_instr & EX_RF_enable &
              ((ID_use_Rn & (ID_Rn == EX_RD)) |
               (ID_use_Rm & (ID_Rm == EX_RD)) |
               (ID_use_Rd & (ID_Rd == EX_RD)));

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= next_state;
      // STALL and FLUSH never self-loop, so every edge into them is a new event
      if (next_state == STALL && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (next_state == FLUSH && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    next_state  = RUN;
    PC_LE       = 1'b1;
    IF_ID_LE    = 1'b1;
    IF_ID_flush = 1'b0;
    CU_MUX_E    = 1'b0;
    if (Clr) begin
      CU_MUX_E = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          // load-use wins over a taken branch; the branch is retried in STALL
          if (lu) begin
            PC_LE      = 1'b0;
            IF_ID_LE   = 1'b0;
            CU_MUX_E   = 1'b1;
            next_state = STALL;
          end else if (Branch_taken) begin
            IF_ID_flush = 1'b1;
            next_state  = FLUSH;
          end
        end
        STALL: begin
          if (Branch_taken) begin
            IF_ID_flush = 1'b1;
            next_state  = FLUSH;
          end
        end
        FLUSH: ;
        default: ;
      endcase
    end
  end

  always_comb begin
    FWD_A = 2'b00;
    FWD_B = 2'b00;
    FWD_D = 2'b00;
    if (!Clr) begin
      FWD_A = fwd_sel(ID_Rn, ID_use_Rn, EX_RD, EX_RF_enable & ~EX_load_instr,
                      MEM_RD, MEM_RF_enable, WB_RD, WB_RF_enable);
      FWD_B = fwd_sel(ID_Rm, ID_use_Rm, EX_RD, EX_RF_enable & ~EX_load_instr,
                      MEM_RD, MEM_RF_enable, WB_RD, WB_RF_enable);
      FWD_D = fwd_sel(ID_Rd, ID_use_Rd, EX_RD, EX_RF_enable & ~EX_load_instr,
                      MEM_RD, MEM_RF_enable, WB_RD, WB_RF_enable);
    end
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter: CNT_W, default 8, width of the saturating stall and flush counters.
REQ-002 Clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Clr  input  1  reset, asynchronous, active-high.
REQ-004 ID_Rn, ID_Rm, ID_Rd  input  4 each  source register fields of the instruction in ID (Rd is the store-data source).
REQ-005 ID_use_Rn, ID_use_Rm, ID_use_Rd  input  1 each  the matching source field is actually read.
REQ-006 EX_RD  input  4, EX_RF_enable  input  1, EX_load_instr  input  1  destination and type of the instruction in EX.
REQ-007 MEM_RD  input  4, MEM_RF_enable  input  1  destination and write enable of the instruction in MEM.
REQ-008 WB_RD  input  4, WB_RF_enable  input  1  destination and write enable of the instruction in WB.
REQ-009 Branch_taken  input  1  a B/BL in ID has resolved taken this cycle.
REQ-010 PC_LE  output  1  PC load enable.
REQ-011 IF_ID_LE  output  1  IF/ID load enable.
REQ-012 IF_ID_flush  output  1  clear IF/ID on the next edge.
REQ-013 CU_MUX_E  output  1  1 selects all-zero (NOP) control into ID/EX.
REQ-014 FWD_A, FWD_B, FWD_D  output  2 each  operand source for Rn, Rm, Rd: 00 register file, 01 EX, 10 MEM, 11 WB.
REQ-015 stall_cnt, flush_cnt  output  CNT_W each  performance counters.

Function
REQ-016 FSM states: RUN, STALL, FLUSH; state is registered; control outputs are combinational from state and inputs.
REQ-017 Load-use hazard (LU) = EX_load_instr & EX_RF_enable & any enabled ID source equal to EX_RD.
REQ-018 RUN with LU: PC_LE=0, IF_ID_LE=0, CU_MUX_E=1, IF_ID_flush=0; next state STALL.
REQ-019 RUN with Branch_taken and no LU: PC_LE=1, IF_ID_LE=1, CU_MUX_E=0, IF_ID_flush=1; next state FLUSH.
REQ-020 RUN with neither: PC_LE=1, IF_ID_LE=1, CU_MUX_E=0, IF_ID_flush=0; stay in RUN.
REQ-021 LU and Branch_taken in the same cycle: LU wins; the branch stays in ID and is re-evaluated in STALL.
REQ-022 STALL: LU is ignored (EX holds a bubble); Branch_taken behaves as in RUN (next state FLUSH); otherwise next state RUN with normal outputs.
REQ-023 FLUSH: ID holds a squashed instruction; LU and Branch_taken are ignored; outputs normal; next state RUN.
REQ-024 Any load-use stall lasts exactly one cycle.
REQ-025 Forwarding per source field, priority EX > MEM > WB:
- 01 when EX_RF_enable & !EX_load_instr & match;
- else 10 when MEM_RF_enable & match;
- else 11 when WB_RF_enable & match;
- else 00.
REQ-026 A source field of 4'd15 (PC), or a field whose use bit is 0, always yields FWD=00.
REQ-027 stall_cnt increments on each edge that enters STALL; flush_cnt increments on each edge that enters FLUSH; both saturate at 2^CNT_W-1 and do not wrap.

Reset
REQ-028 Clr=1 forces, asynchronously: state=RUN, stall_cnt=0, flush_cnt=0.
REQ-029 While Clr=1: PC_LE=1, IF_ID_LE=1, IF_ID_flush=0, CU_MUX_E=1, all FWD=00.
REQ-030 Clr asserted mid-STALL or mid-FLUSH aborts the operation; the first edge after release evaluates from RUN.

Verification
REQ-031 EX LDR R3, ID ADD using Rn=R3 -> 1 cycle of PC_LE=0, IF_ID_LE=0, CU_MUX_E=1; next cycle RUN, FWD_A=10; stall_cnt=1.
REQ-032 EX ADD writing R2, MEM writing R2, ID reads Rm=R2 -> FWD_B=01; remove EX write -> FWD_B=10; WB-only match -> 11.
REQ-033 Branch_taken=1 in RUN -> IF_ID_flush=1 for 1 cycle; Branch_taken held next cycle -> ignored in FLUSH; flush_cnt=1.
REQ-034 LU and Branch_taken together -> stall first, IF_ID_flush=1 in the STALL cycle, then FLUSH, then RUN.
REQ-035 CNT_W=2 with 5 back-to-back load-use pairs -> stall_cnt saturates at 3; Clr pulse mid-STALL -> state RUN, counters 0, CU_MUX_E=1 during reset.
